sseg_scan_driver: RTL and testbench
===================================

// Module: sseg_scan_driver
// PURPOSE
//  Time-multiplexed scan controller for a DIGITS-wide common-anode seven-segment display.
//  Sits on both sides of the hexto7segment decoder:
//   - upstream: drives its 4-bit nibble input;
//   - downstream: registers its 7-bit segment output onto the pins.
//  Buffers one pending display word so host updates apply atomically at frame boundaries.
//  Inserts blanking between digit slots to suppress ghosting.
// PARAMETERS
//  DIGITS           4     number of digits scanned; digit 0 = load_data[3:0]
//  PRESCALE         1000  clk cycles each digit is lit per slot (>=1)
//  BLANK_CYCLES     2     clk cycles all digits dark between slots (>=0)
//  ANODE_ACTIVE_LOW 1     1: an bit =0 lights digit; 0: an bit =1 lights digit
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  reset_n     in   1          asynchronous active-low reset
//  load_valid  in   1          host offers new display word
//  load_ready  out  1          pending buffer empty; word accepted when valid&&ready
//  load_data   in   4*DIGITS   hex nibbles, digit i = load_data[4*i+3:4*i]
//  load_dp     in   DIGITS     decimal point per digit, latched with load_data
//  nibble_out  out  4          to decoder input: nibble of current digit index
//  seg_in      in   7          from decoder output (combinational from nibble_out)
//  an          out  DIGITS     anode enables, polarity per ANODE_ACTIVE_LOW
//  seg         out  7          registered segment pattern, 7'h00 when dark
//  dp          out  1          registered decimal point, 0 when dark
//  frame_done  out  1          1-cycle pulse at end of the last digit's lit slot
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=BLANK, idx=0, cnt=0;
//   - display word=0, display dp=0, pending empty;
//   - an all inactive, seg=7'h00, dp=0, frame_done=0, load_ready=1.
//  nibble_out = display[4*idx+3:4*idx]; combinational from registered idx.
//  FSM states:
//   - BLANK:
//     - Count BLANK_CYCLES cycles, then go to LIT and clear cnt.
//     - BLANK_CYCLES=0: BLANK lasts 0 cycles (LIT follows LIT directly).
//   - LIT:
//     - Count PRESCALE cycles.
//     - On the last cycle: idx <= (idx==DIGITS-1) ? 0 : idx+1, then go to BLANK.
//  Outputs are registered from the current state:
//   - next an: only bit idx active while in LIT, else all inactive;
//   - next seg = LIT ? seg_in : 7'h00;
//   - next dp  = LIT ? display_dp[idx] : 0;
//   - each digit is therefore lit exactly PRESCALE cycles, one cycle behind state.
//  Frame period = DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
//  Frame wrap = last LIT cycle of idx DIGITS-1:
//   - frame_done asserted the following cycle, for 1 cycle;
//   - if pending full: display <= pending, pending emptied.
//  Load handshake:
//   - load_ready = !pending_full;
//   - accept = load_valid && load_ready; data captured into pending that edge.
//   - Wrap and accept in the same cycle cannot occur (ready is 0 when wrap commits).
//   - A word accepted on the wrap edge of an empty buffer waits one full frame.
//   - A valid held while ready=0 is not captured; the host keeps load_data stable.
//  Display contents never change mid-frame (no torn digits).
//  idx never exceeds DIGITS-1; cnt widths are sized by $clog2 of PRESCALE/BLANK_CYCLES.
//  reset_n low mid-slot: outputs go dark immediately (async); pending word is discarded.
// TESTING  (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1, real hexto7segment)
//  1. Reset held 5 cycles -> an=4'hF, seg=0, dp=0, load_ready=1, nibble_out=0, frame_done=0.
//  2. Load 16'h1234, dp=4'b0010, mid-frame -> ready drops 1 cycle later; at next wrap display
//     updates; next frame: an=4'hE with seg=decode(4), then 4'hD with seg=decode(3) and dp=1,
//     then decode(2), decode(1); each lit 8 cycles, 2 dark cycles between.
//  3. Free-run 3 frames -> frame_done pulses exactly every 40 cycles, 1 cycle wide; an never has
//     more than one 0 bit; never changes directly from one lit digit to another.
//  4. Load 16'hAAAA, then hold valid with 16'h5555 -> second word waits (ready=0) until wrap,
//     then is accepted; display shows AAAA for one full frame, then 5555; no frame mixes both.
//  5. Assert reset_n low during digit 2's lit slot -> an=4'hF and seg=0 the same cycle
//     (async); after release, scan restarts at digit 0 showing 0000 and pending is empty.
//  6. BLANK_CYCLES=0, PRESCALE=1 build -> an rotates E,D,B,7 one per cycle; frame_done every 4 cycles.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - time-multiplexed seven-segment scan controller with frame-atomic display updates
module sseg_scan_driver #(
  parameter int DIGITS           = 4,
  parameter int PRESCALE         = 1000,
  parameter int BLANK_CYCLES     = 2,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  output logic [3:0]            nibble_out,
  input  logic [6:0]            seg_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int CW = (PW > BW) ? PW : BW;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam bit            NO_BLANK   = (BLANK_CYCLES == 0);
  localparam logic [DIGITS-1:0] AN_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {BLANK = 1'b0, LIT = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  wrap;
  logic [4*DIGITS-1:0]   display, pending;
  logic [DIGITS-1:0]     display_dp, pending_dp;
  logic                  pending_full;
  logic [DIGITS-1:0]     onehot;

  assign load_ready = !pending_full;
  assign nibble_out = display[{idx, 2'b00} +: 4];
  assign onehot     = DIGITS'(1) << idx;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap      = 1'b0;
    case (state)
      BLANK: begin
        if (NO_BLANK || cnt == BLANK_LAST) begin
          state_nxt = LIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LIT: begin
        if (cnt == PRE_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          wrap      = (idx == IDX_LAST);
          // Without blanking the next digit's slot starts immediately.
          state_nxt = NO_BLANK ? LIT : BLANK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BLANK;
      cnt          <= '0;
      idx          <= '0;
      display      <= '0;
      display_dp   <= '0;
      pending      <= '0;
      pending_dp   <= '0;
      pending_full <= 1'b0;
      an           <= AN_OFF;
      seg          <= 7'h00;
      dp           <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_done <= wrap;
      // Swap only at the frame wrap so no frame ever mixes two words.
      if (wrap && pending_full) begin
        display      <= pending;
        display_dp   <= pending_dp;
        pending_full <= 1'b0;
      end else if (load_valid && !pending_full) begin
        pending      <= load_data;
        pending_dp   <= load_dp;
        pending_full <= 1'b1;
      end
      if (state == LIT) begin
        an  <= ANODE_ACTIVE_LOW ? ~onehot : onehot;
        seg <= seg_in;
        dp  <= display_dp[idx];
      end else begin
        an  <= AN_OFF;
        seg <= 7'h00;
        dp  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - directed self-checking bench for sseg_scan_driver
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;
  logic [3:0]  nibble_out;
  logic [6:0]  seg_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  logic        load_ready_f;
  logic [3:0]  nibble_f;
  logic [6:0]  seg_in_f;
  logic [3:0]  an_f;
  logic [6:0]  seg_f;
  logic        dp_f;
  logic        frame_done_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  assign seg_in   = hex7(nibble_out);
  assign seg_in_f = hex7(nibble_f);

  sseg_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .nibble_out(nibble_out), .seg_in(seg_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  sseg_scan_driver #(.DIGITS(4), .PRESCALE(1), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1)) u_fast (
    .clk(clk), .reset_n(reset_n), .load_valid(1'b0), .load_ready(load_ready_f),
    .load_data(16'h0000), .load_dp(4'h0), .nibble_out(nibble_f), .seg_in(seg_in_f),
    .an(an_f), .seg(seg_f), .dp(dp_f), .frame_done(frame_done_f)
  );

  // Sample k counts negedges after the frame_done sample (k=0); k=40 is the next frame_done.
  function automatic logic [3:0] exp_an(input int k);
    int pos = k - 1;
    if (pos % 10 < 2) return 4'hF;
    return ~(4'b0001 << (pos / 10));
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] w, input int k);
    int pos = k - 1;
    if (pos % 10 < 2) return 7'h00;
    return hex7(w[(pos / 10) * 4 +: 4]);
  endfunction

  function automatic logic exp_dp(input logic [3:0] d, input int k);
    int pos = k - 1;
    if (pos % 10 < 2) return 1'b0;
    return d[pos / 10];
  endfunction

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_done timeout: got %b want 1", tag, frame_done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_valid = 1'b0;
    load_data = 16'h0000;
    load_dp = 4'h0;
    repeat (5) @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h00 || dp !== 1'b0 || load_ready !== 1'b1 ||
        nibble_out !== 4'h0 || frame_done !== 1'b0 || an_f !== 4'hF) begin
      failures++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b rdy=%b nib=%h fd=%b an_f=%h want F 00 0 1 0 0 F",
               an, seg, dp, load_ready, nibble_out, frame_done, an_f);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    wait_frame("load_sync");
    repeat (5) @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready_idle: got %b want 1", load_ready);
    end
    load_valid = 1'b1;
    load_data = 16'h1234;
    load_dp = 4'b0010;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_ready_drop: got %b want 0", load_ready);
    end
    wait_frame("load_wrap");
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready_after_wrap: got %b want 1", load_ready);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an(k) || seg !== exp_seg(16'h1234, k) || dp !== exp_dp(4'b0010, k) ||
          frame_done !== (k == 40)) begin
        failures++;
        $display("FAIL load_frame k=%0d an=%h/%h seg=%h/%h dp=%b/%b fd=%b (got/want)",
                 k, an, exp_an(k), seg, exp_seg(16'h1234, k), dp, exp_dp(4'b0010, k), frame_done);
      end
    end
  endtask

  task automatic test_free_run();
    logic [3:0] prev_an = an;
    int zeros;
    for (int j = 1; j <= 120; j++) begin
      @(negedge clk);
      zeros = 0;
      for (int b = 0; b < 4; b++) if (an[b] == 1'b0) zeros++;
      checks++;
      if (frame_done !== (j % 40 == 0)) begin
        failures++;
        $display("FAIL free_run_frame_done j=%0d got %b want %b", j, frame_done, (j % 40 == 0));
      end
      checks++;
      if (zeros > 1) begin
        failures++;
        $display("FAIL free_run_onehot j=%0d an=%h lit_count=%0d want <=1", j, an, zeros);
      end
      checks++;
      if (prev_an != 4'hF && an != 4'hF && an != prev_an) begin
        failures++;
        $display("FAIL free_run_no_blank j=%0d an %h -> %h want dark gap", j, prev_an, an);
      end
      prev_an = an;
    end
  endtask

  task automatic test_back_to_back();
    load_valid = 1'b1;
    load_data = 16'hAAAA;
    load_dp = 4'h0;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_accept: ready got %b want 0", load_ready);
    end
    load_data = 16'h5555;
    for (int k = 2; k <= 39; k++) begin
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hold k=%0d ready got %b want 0", k, load_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_wrap fd=%b ready=%b want 1 1", frame_done, load_ready);
    end
    for (int f = 0; f < 2; f++) begin
      logic [15:0] w = (f == 0) ? 16'hAAAA : 16'h5555;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (f == 0 && k == 1) begin
          load_valid = 1'b0;
          checks++;
          if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept: ready got %b want 0", load_ready);
          end
        end
        checks++;
        if (an !== exp_an(k) || seg !== exp_seg(w, k) || dp !== 1'b0 || frame_done !== (k == 40)) begin
          failures++;
          $display("FAIL b2b_frame%0d k=%0d an=%h/%h seg=%h/%h dp=%b fd=%b (got/want)",
                   f, k, an, exp_an(k), seg, exp_seg(w, k), dp, frame_done);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (5) @(negedge clk);
    load_valid = 1'b1;
    load_data = 16'h9999;
    load_dp = 4'hF;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (an !== 4'hB || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL areset_pre an=%h ready=%b want B 0", an, load_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h00 || dp !== 1'b0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_immediate an=%h seg=%h dp=%b ready=%b want F 00 0 1", an, seg, dp, load_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an(s) || seg !== exp_seg(16'h0000, s) || dp !== 1'b0 ||
          frame_done !== (s == 40) || load_ready !== 1'b1) begin
        failures++;
        $display("FAIL areset_restart s=%0d an=%h/%h seg=%h/%h dp=%b fd=%b rdy=%b (got/want)",
                 s, an, exp_an(s), seg, exp_seg(16'h0000, s), dp, frame_done, load_ready);
      end
      if (s == 3) begin
        checks++;
        if (nibble_out !== 4'h0) begin
          failures++;
          $display("FAIL areset_nibble got %h want 0", nibble_out);
        end
      end
    end
  endtask

  task automatic test_no_blank();
    logic [3:0] seq [4];
    int n = 0;
    seq[0] = 4'hE; seq[1] = 4'hD; seq[2] = 4'hB; seq[3] = 4'h7;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done_f && n < 50);
    checks++;
    if (frame_done_f !== 1'b1) begin
      failures++;
      $display("FAIL fast_frame_done timeout got %b want 1", frame_done_f);
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++;
      if (an_f !== seq[(j - 1) % 4] || frame_done_f !== (j % 4 == 0) ||
          seg_f !== 7'h3F || dp_f !== 1'b0 || load_ready_f !== 1'b1) begin
        failures++;
        $display("FAIL fast_rotate j=%0d an=%h want %h fd=%b want %b seg=%h want 3f dp=%b rdy=%b",
                 j, an_f, seq[(j - 1) % 4], frame_done_f, (j % 4 == 0), seg_f, dp_f, load_ready_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_free_run();
    test_back_to_back();
    test_async_reset();
    test_no_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
